// File: rtl/mux157_arbiter.sv
// rtl/mux157_arbiter.sv - round-robin arbiter sharing one SN74LS157 quad 2:1 mux between sources A and B
//
// Optional feature: define MUX157_ARB_BLANK_EN to insert one BLANK cycle
// (G_bar = 1, no grant) on every exit from OWN_A / OWN_B.
module mux157_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic REQ_A,
  input  logic REQ_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic SELECT,
  output logic G_bar
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    BLANK = 2'd3
  } state_t;

  // LAST encoding: which source was served most recently.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  // Counter value at which the owner has used up its HOLD_MAX cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HCNT_MAX  = '1;
  localparam logic             PREEMPT_ON = (HOLD_MAX != 0);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             select_q, select_d;
  logic             g_bar_q, g_bar_d;

  logic [1:0]       arb_now;
  logic             preempt_a;
  logic             preempt_b;
  logic [CNT_W-1:0] hcnt_inc;

  // Arbitration: {valid, winner_is_b}. On a tie the source that is not LAST wins.
  function automatic logic [1:0] arb(input logic ra, input logic rb, input logic last);
    if (ra && rb) begin
      return {1'b1, ~last};
    end else if (ra) begin
      return 2'b10;
    end else if (rb) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  // Map an arbitration result onto the owner state it leads to.
  function automatic state_t arb_state(input logic [1:0] g);
    if (!g[1]) begin
      return IDLE;
    end else if (g[0]) begin
      return OWN_B;
    end else begin
      return OWN_A;
    end
  endfunction

  // Preemption terms and the saturating hold-count increment.
  always_comb begin
    arb_now   = arb(REQ_A, REQ_B, last_q);
    preempt_a = PREEMPT_ON && REQ_B && (hcnt_q == HOLD_LAST);
    preempt_b = PREEMPT_ON && REQ_A && (hcnt_q == HOLD_LAST);
    hcnt_inc  = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 1'b1;
  end

  // Next-state, LAST and hold-counter logic; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hcnt_d  = '0;

    case (state_q)
      IDLE, BLANK: begin
        state_d = arb_state(arb_now);
      end

      OWN_A: begin
        if (!REQ_A || preempt_a) begin
          last_d = LAST_A;
`ifdef MUX157_ARB_BLANK_EN
          state_d = BLANK;
`else
          state_d = arb_state(arb(REQ_A, REQ_B, LAST_A));
`endif
        end else begin
          state_d = OWN_A;
          hcnt_d  = hcnt_inc;
        end
      end

      OWN_B: begin
        if (!REQ_B || preempt_b) begin
          last_d = LAST_B;
`ifdef MUX157_ARB_BLANK_EN
          state_d = BLANK;
`else
          state_d = arb_state(arb(REQ_A, REQ_B, LAST_B));
`endif
        end else begin
          state_d = OWN_B;
          hcnt_d  = hcnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over everything, including an active grant: no BLANK cycle.
    if (CLR) begin
      state_d = IDLE;
      last_d  = LAST_B;
      hcnt_d  = '0;
    end

    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    g_bar_d = !(gnt_a_d || gnt_b_d);

    // SELECT only moves together with a new grant; otherwise it holds.
    if (CLR) begin
      select_d = 1'b0;
    end else if (state_d == OWN_A) begin
      select_d = 1'b0;
    end else if (state_d == OWN_B) begin
      select_d = 1'b1;
    end else begin
      select_d = select_q;
    end
  end

  // State and registered-output flops; reset values come through the _d path.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= IDLE;
      last_q   <= LAST_B;
      hcnt_q   <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      select_q <= 1'b0;
      g_bar_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      hcnt_q   <= hcnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      select_q <= select_d;
      g_bar_q  <= g_bar_d;
    end
  end

  assign GNT_A  = gnt_a_q;
  assign GNT_B  = gnt_b_q;
  assign SELECT = select_q;
  assign G_bar  = g_bar_q;

endmodule

// File: tb/tb_mux157_arbiter.sv
// tb/tb_mux157_arbiter.sv - scoreboard bench for mux157_arbiter (HOLD_MAX=3 and HOLD_MAX=0 instances)
module tb_mux157_arbiter;

  // Output vector order: {GNT_A, GNT_B, SELECT, G_bar}
  localparam logic [3:0] OA = 4'b1000;
  localparam logic [3:0] OB = 4'b0110;
  localparam logic [3:0] I0 = 4'b0001;
  localparam logic [3:0] I1 = 4'b0011;

  logic CLK;
  logic CLR;
  logic REQ_A;
  logic REQ_B;
  logic gnt_a3, gnt_b3, sel3, gbar3;
  logic gnt_a0, gnt_b0, sel0, gbar0;

  int cyc;
  int n_checks;
  int n_fail;

  typedef struct {
    int         tag;
    logic [3:0] exp3;
    logic [3:0] exp0;
    string      name;
  } exp_t;

  exp_t sb_q[$];

  mux157_arbiter #(.HOLD_MAX(3), .CNT_W(4)) dut3 (
    .CLK   (CLK),
    .CLR   (CLR),
    .REQ_A (REQ_A),
    .REQ_B (REQ_B),
    .GNT_A (gnt_a3),
    .GNT_B (gnt_b3),
    .SELECT(sel3),
    .G_bar (gbar3)
  );

  mux157_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut0 (
    .CLK   (CLK),
    .CLR   (CLR),
    .REQ_A (REQ_A),
    .REQ_B (REQ_B),
    .GNT_A (gnt_a0),
    .GNT_B (gnt_b0),
    .SELECT(sel0),
    .G_bar (gbar0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: each cycle check grant exclusivity and pop the expectations due now.
  always @(negedge CLK) begin
    exp_t e;
    if (cyc > 0) begin
      n_checks = n_checks + 2;
      if (gnt_a3 && gnt_b3) begin
        n_fail = n_fail + 1;
        $display("FAIL mutex dut3 cycle %0d: GNT_A=%b GNT_B=%b, required not both 1", cyc, gnt_a3, gnt_b3);
      end
      if (gnt_a0 && gnt_b0) begin
        n_fail = n_fail + 1;
        $display("FAIL mutex dut0 cycle %0d: GNT_A=%b GNT_B=%b, required not both 1", cyc, gnt_a0, gnt_b0);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
      e = sb_q.pop_front();
      n_checks = n_checks + 1;
      if (e.tag < cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s stale entry: due cycle %0d, checked at %0d", e.name, e.tag, cyc);
      end else begin
        if ({gnt_a3, gnt_b3, sel3, gbar3} !== e.exp3) begin
          n_fail = n_fail + 1;
          $display("FAIL %s dut3 cycle %0d: got %b required %b", e.name, cyc,
                   {gnt_a3, gnt_b3, sel3, gbar3}, e.exp3);
        end
        n_checks = n_checks + 1;
        if ({gnt_a0, gnt_b0, sel0, gbar0} !== e.exp0) begin
          n_fail = n_fail + 1;
          $display("FAIL %s dut0 cycle %0d: got %b required %b", e.name, cyc,
                   {gnt_a0, gnt_b0, sel0, gbar0}, e.exp0);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic clr, input logic a, input logic b,
                      input logic [3:0] e3, input logic [3:0] e0, input string nm);
    exp_t e;
    @(negedge CLK);
    CLR   = clr;
    REQ_A = a;
    REQ_B = b;
    e.tag  = cyc + 1;
    e.exp3 = e3;
    e.exp0 = e0;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    CLR   = 1'b1;
    REQ_A = 1'b0;
    REQ_B = 1'b0;

    // Reset with both requests high, then A wins the first tie.
    step(1'b1, 1'b1, 1'b1, I0, I0, "reset_1");
    step(1'b1, 1'b1, 1'b1, I0, I0, "reset_2");
    step(1'b0, 1'b1, 1'b1, OA, OA, "first_tie_a");
    step(1'b0, 1'b0, 1'b0, I0, I0, "release_a");
    step(1'b0, 1'b0, 1'b0, I0, I0, "idle_a");

    // Single requester B for five cycles.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, OB, OB, "single_b");
    step(1'b0, 1'b0, 1'b0, I1, I1, "release_b");
    step(1'b0, 1'b0, 1'b0, I1, I1, "idle_sel_b");

    // Both requests held: round-robin with HOLD_MAX=3, HOLD_MAX=0 keeps A.
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_0");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_1");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_2");
`ifdef MUX157_ARB_BLANK_EN
    step(1'b0, 1'b1, 1'b1, I0, OA, "rr_blank_3");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_4");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_5");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_6");
    step(1'b0, 1'b1, 1'b1, I1, OA, "rr_blank_7");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_8");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_9");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_10");
    step(1'b0, 1'b1, 1'b1, I0, OA, "rr_blank_11");
    step(1'b0, 1'b0, 1'b0, I0, I0, "drop_all_1");
    step(1'b0, 1'b0, 1'b0, I0, I0, "drop_all_2");
`else
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_3");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_4");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_5");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_6");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_7");
    step(1'b0, 1'b1, 1'b1, OA, OA, "rr_8");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_9");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_10");
    step(1'b0, 1'b1, 1'b1, OB, OA, "rr_11");
    step(1'b0, 1'b0, 1'b0, I1, I0, "drop_all_1");
    step(1'b0, 1'b0, 1'b0, I1, I0, "drop_all_2");
`endif

    // A alone, then B joins; preemption after exactly three cycles on dut3.
    step(1'b0, 1'b1, 1'b0, OA, OA, "a_alone");
    step(1'b0, 1'b1, 1'b1, OA, OA, "hold_1");
    step(1'b0, 1'b1, 1'b1, OA, OA, "hold_2");
`ifdef MUX157_ARB_BLANK_EN
    step(1'b0, 1'b1, 1'b1, I0, OA, "preempt_blank");
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_b_1");
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_b_2");
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_b_3");
    step(1'b0, 1'b0, 1'b1, OB, I0, "a_drops_blank");
    step(1'b0, 1'b0, 1'b1, OB, OB, "b_after_a");
`else
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_direct");
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_b_1");
    step(1'b0, 1'b1, 1'b1, OB, OA, "preempt_b_2");
    step(1'b0, 1'b1, 1'b1, OA, OA, "preempt_back_a");
    step(1'b0, 1'b0, 1'b1, OB, OB, "direct_handover");
    step(1'b0, 1'b0, 1'b1, OB, OB, "b_after_a");
`endif

    // Clear during OWN_B, then A wins the next tie.
    step(1'b1, 1'b1, 1'b1, I0, I0, "clr_in_own_b");
    step(1'b0, 1'b1, 1'b1, OA, OA, "tie_after_clr");
    step(1'b0, 1'b0, 1'b0, I0, I0, "final_release");
    step(1'b0, 1'b0, 1'b0, I0, I0, "final_idle");

    repeat (2) @(negedge CLK);
    #1;
    n_checks = n_checks + 1;
    if (sb_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
